ss_scan_driver: RTL

SS_SCAN_DRIVER -- requirements
Module: ss_scan_driver

---
 rtl/ss_pkg.sv | 47 ++++
 rtl/ss_hex_decoder.sv | 12 +
 rtl/ss_scan_driver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared types, segment patterns and hex-to-segment function for the scan driver
package ss_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;   // active-low {a,b,c,d,e,f,g}, MSB = a

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  function automatic seg_t hex_to_seg(input nibble_t h);
    case (h)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/ss_hex_decoder.sv
// rtl/ss_hex_decoder.sv - combinational hex nibble to active-low 7-segment decoder
module ss_hex_decoder
  import ss_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // pure lookup, no state
  assign seg_n = hex_to_seg(hex);

endmodule

// File: rtl/ss_scan_driver.sv
// rtl/ss_scan_driver.sv - multiplexed 7-seg scan driver; define SS_LEADING_ZERO_BLANK_EN for leading-zero blanking
module ss_scan_driver
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 200000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    update_ack
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_digits, shadow_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, shadow_dp;
  logic                    pend_valid;
  logic                    slot_end, frame_end;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    blank;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_end  = slot_end && (idx == IDX_LAST);
  assign frame_done = frame_end;
  assign update_ack = frame_end && (pend_valid || load);

  // slot counter and digit index; index advances once per slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // pending capture and frame-boundary commit; a load in the wrap cycle bypasses pending
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_digits   <= '0;
      pend_dp       <= '0;
      pend_valid    <= 1'b0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_valid  <= 1'b1;
      end
      if (frame_end) begin
        if (load) begin
          shadow_digits <= digits_in;
          shadow_dp     <= dp_in;
        end else if (pend_valid) begin
          shadow_digits <= pend_digits;
          shadow_dp     <= pend_dp;
        end
        pend_valid <= 1'b0;
      end
    end
  end

  assign cur_nib = shadow_digits[{idx, 2'b00} +: 4];

  ss_hex_decoder u_dec (
    .hex   (cur_nib),
    .seg_n (dec_seg)
  );

`ifdef SS_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // blank when this and every higher digit is zero, except digit 0 or a lit dp
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && shadow_digits[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blank = upper_zero && (idx != '0) && !shadow_dp[idx];
  end
`else
  assign blank = 1'b0;
`endif

  // anode select: all off during the guard window, else only the current digit
  always_comb begin
    anodes = '1;
    if (cnt >= CNT_GUARD) anodes[idx] = 1'b0;
  end

  // registered display outputs, one cycle behind counter/index
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= blank ? SEG_BLANK : dec_seg;
      dp_n  <= ~shadow_dp[idx];
      an_n  <= anodes;
    end
  end

endmodule
